// File: rtl/tx_ser_pkg.sv
// Shared types and PRBS7 helpers for the TX serializer.
package tx_ser_pkg;

    typedef enum logic [1:0] {
        DATA  = 2'd0,
        PRBS7 = 2'd1,
        CLK   = 2'd2,
        ZERO  = 2'd3
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int unsigned PRBS7_LEN    = 7;
    localparam int unsigned PRBS7_TAP_HI = 6;
    localparam int unsigned PRBS7_TAP_LO = 5;

    // x^7 + x^6 + 1, Fibonacci form; the output bit is s[6].
    function automatic logic [PRBS7_LEN-1:0] prbs7_next(input logic [PRBS7_LEN-1:0] s);
        return {s[PRBS7_LEN-2:0], s[PRBS7_TAP_HI] ^ s[PRBS7_TAP_LO]};
    endfunction

endpackage

// File: rtl/tx_serializer_prbs7_gen.sv
// PRBS7 LFSR that advances one state per asserted step.
module prbs7_gen
    import tx_ser_pkg::*;
#(
    parameter logic [6:0] SEED = 7'h7F
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step_i,
    output logic [6:0] lfsr_o
);

    // An all-zero seed would lock the LFSR, so it is replaced.
    localparam logic [6:0] SEED_EFF = (SEED == 7'h00) ? 7'h01 : SEED;

    logic [6:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = step_i ? prbs7_next(lfsr_q) : lfsr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED_EFF;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/tx_serializer.sv
// Word-to-bit serializer with PRBS7/clock/zero patterns and PRBS7 gap fill.
module tx_serializer
    import tx_ser_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b1,
    parameter logic [6:0]  PRBS_SEED = 7'h7F
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic [1:0]       mode,
    output logic             out,
    output logic             frame,
    output logic             underrun
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_v_q, hold_v_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             frame_q, frame_d;
    logic             underrun_q, underrun_d;
    logic             fill_q, fill_d;
    logic             prbs_word_q, prbs_word_d;

    logic             last;
    logic             xfer;
    logic             load;
    logic             consume;
    logic             lfsr_step;
    logic [6:0]       lfsr;
    logic [6:0]       prbs_base;

    // Maps a word given in serialization order onto the shift register layout.
    function automatic logic [WIDTH-1:0] to_sreg(input logic [WIDTH-1:0] seq);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            r[i] = LSB_FIRST ? seq[i] : seq[WIDTH-1-i];
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] prbs_word(input logic [6:0] start);
        logic [6:0]       s;
        logic [WIDTH-1:0] seq;
        s   = start;
        seq = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            seq[i] = s[6];
            s      = prbs7_next(s);
        end
        return to_sreg(seq);
    endfunction

    function automatic logic [WIDTH-1:0] clk_word();
        logic [WIDTH-1:0] seq;
        seq = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            seq[i] = ((i % 2) == 0);
        end
        return to_sreg(seq);
    endfunction

    assign last      = (state_q == RUN) && (cnt_q == CNT_LAST);
    assign din_ready = ~hold_v_q | last;
    assign xfer      = din_valid & din_ready;

    // The LFSR steps once per emitted PRBS bit; a word loaded on the same edge
    // as the final step must start from the post-step state.
    assign lfsr_step = (state_q == RUN) & prbs_word_q;
    assign prbs_base = lfsr_step ? prbs7_next(lfsr) : lfsr;

    prbs7_gen #(
        .SEED(PRBS_SEED)
    ) u_prbs7_gen (
        .clk   (clk),
        .rst   (rst),
        .step_i(lfsr_step),
        .lfsr_o(lfsr)
    );

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_v_d    = hold_v_q;
        sreg_d      = sreg_q;
        cnt_d       = cnt_q;
        out_d       = 1'b0;
        frame_d     = 1'b0;
        underrun_d  = 1'b0;
        fill_d      = 1'b0;
        prbs_word_d = prbs_word_q;
        load        = 1'b0;
        consume     = 1'b0;

        if (state_q == IDLE) begin
            if (hold_v_q || (mode_e'(mode) != DATA)) begin
                state_d = RUN;
                load    = 1'b1;
            end
        end else begin
            out_d      = LSB_FIRST ? sreg_q[0] : sreg_q[WIDTH-1];
            frame_d    = (cnt_q == '0);
            underrun_d = fill_q;
            sreg_d     = LSB_FIRST ? (sreg_q >> 1) : (sreg_q << 1);
            cnt_d      = last ? '0 : cnt_q + 1'b1;
            load       = last;
        end

        if (load) begin
            case (mode_e'(mode))
                DATA: begin
                    if (hold_v_q) begin
                        sreg_d      = hold_q;
                        consume     = 1'b1;
                        prbs_word_d = 1'b0;
                    end else begin
                        sreg_d      = prbs_word(prbs_base);
                        fill_d      = 1'b1;
                        prbs_word_d = 1'b1;
                    end
                end
                PRBS7: begin
                    sreg_d      = prbs_word(prbs_base);
                    prbs_word_d = 1'b1;
                end
                CLK: begin
                    sreg_d      = clk_word();
                    prbs_word_d = 1'b0;
                end
                ZERO: begin
                    sreg_d      = '0;
                    prbs_word_d = 1'b0;
                end
                default: begin
                    sreg_d      = '0;
                    prbs_word_d = 1'b0;
                end
            endcase
        end

        if (xfer) begin
            hold_d   = din;
            hold_v_d = 1'b1;
        end else if (consume) begin
            hold_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_v_q    <= 1'b0;
            sreg_q      <= '0;
            cnt_q       <= '0;
            out_q       <= 1'b0;
            frame_q     <= 1'b0;
            underrun_q  <= 1'b0;
            fill_q      <= 1'b0;
            prbs_word_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_v_q    <= hold_v_d;
            sreg_q      <= sreg_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            frame_q     <= frame_d;
            underrun_q  <= underrun_d;
            fill_q      <= fill_d;
            prbs_word_q <= prbs_word_d;
        end
    end

    assign out      = out_q;
    assign frame    = frame_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_tx_serializer.sv
// Scoreboard bench for tx_serializer: cycle-stamped expected bits, negedge monitor.
module tb_tx_serializer;

    typedef struct {
        int unsigned cyc;
        logic        o;
        logic        f;
        logic        u;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1, rst_b = 1'b1;
    logic [7:0] din_a = '0;
    logic [3:0] din_b = '0;
    logic       din_valid_a = 1'b0, din_valid_b = 1'b0;
    logic [1:0] mode_a = 2'd0, mode_b = 2'd0;
    logic       ready_a, ready_b, out_a, out_b, frame_a, frame_b, underrun_a, underrun_b;

    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [6:0]  m_lfsr = 7'h7F;
    exp_t        qa[$];
    exp_t        qb[$];

    tx_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .PRBS_SEED(7'h7F)) dut_a (
        .clk(clk), .rst(rst_a), .din(din_a), .din_valid(din_valid_a), .din_ready(ready_a),
        .mode(mode_a), .out(out_a), .frame(frame_a), .underrun(underrun_a)
    );

    tx_serializer #(.WIDTH(4), .LSB_FIRST(1'b0), .PRBS_SEED(7'h7F)) dut_b (
        .clk(clk), .rst(rst_b), .din(din_b), .din_valid(din_valid_b), .din_ready(ready_b),
        .mode(mode_b), .out(out_b), .frame(frame_b), .underrun(underrun_b)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        exp_t e;
        while (qa.size() > 0 && qa[0].cyc <= cyc) begin
            e = qa.pop_front();
            checks++;
            if (e.cyc != cyc || out_a !== e.o || frame_a !== e.f || underrun_a !== e.u) begin
                errors++;
                $display("FAIL bit_a cyc=%0d: got out=%b frame=%b underrun=%b, required out=%b frame=%b underrun=%b",
                         e.cyc, out_a, frame_a, underrun_a, e.o, e.f, e.u);
            end
        end
        while (qb.size() > 0 && qb[0].cyc <= cyc) begin
            e = qb.pop_front();
            checks++;
            if (e.cyc != cyc || out_b !== e.o || frame_b !== e.f || underrun_b !== e.u) begin
                errors++;
                $display("FAIL bit_b cyc=%0d: got out=%b frame=%b underrun=%b, required out=%b frame=%b underrun=%b",
                         e.cyc, out_b, frame_b, underrun_b, e.o, e.f, e.u);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic wait_cyc(input int unsigned c);
        while (cyc < c) @(negedge clk);
    endtask

    // seq holds bits in serialization order (seq[0] goes out first).
    task automatic push_word(input bit b, input int unsigned start, input logic [7:0] seq,
                             input int unsigned n, input bit fill);
        exp_t e;
        for (int unsigned i = 0; i < n; i++) begin
            e.cyc = start + i;
            e.o   = seq[i];
            e.f   = (i == 0);
            e.u   = fill && (i == 0);
            if (b) qb.push_back(e);
            else   qa.push_back(e);
        end
    endtask

    task automatic push_prbs(input int unsigned start, input int unsigned nbits, input bit fill);
        logic [7:0]  seq;
        int unsigned done;
        int unsigned n;
        done = 0;
        while (done < nbits) begin
            n = (nbits - done < 8) ? (nbits - done) : 8;
            for (int unsigned i = 0; i < 8; i++) begin
                seq[i] = m_lfsr[6];
                m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
            end
            push_word(1'b0, start + done, seq, n, fill);
            done += 8;
        end
    endtask

    // Called at a negedge; returns the edge number of the transfer and the
    // following negedge with valid dropped.
    task automatic send(input bit b, input logic [7:0] w, output int unsigned t);
        int unsigned n;
        n = 0;
        if (b) begin din_b = w[3:0]; din_valid_b = 1'b1; end
        else   begin din_a = w;      din_valid_a = 1'b1; end
        while (((b ? ready_b : ready_a) !== 1'b1) && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 40) begin
            errors++;
            $display("FAIL send_ready: din_ready got 0 for 40 cycles, required 1");
        end
        t = cyc + 1;
        @(negedge clk);
        if (b) din_valid_b = 1'b0;
        else   din_valid_a = 1'b0;
    endtask

    task automatic reset_a(input logic [1:0] m);
        @(negedge clk);
        rst_a       = 1'b1;
        din_valid_a = 1'b0;
        mode_a      = m;
        @(negedge clk);
        rst_a  = 1'b0;
        m_lfsr = 7'h7F;
    endtask

    initial begin : stim
        int unsigned t, t2, k, run, maxr;

        repeat (2) @(negedge clk);
        check("reset_out",      {31'd0, out_a},      32'd0);
        check("reset_frame",    {31'd0, frame_a},    32'd0);
        check("reset_underrun", {31'd0, underrun_a}, 32'd0);
        check("reset_ready",    {31'd0, ready_a},    32'd1);
        check("reset_ready_b",  {31'd0, ready_b},    32'd1);
        rst_a = 1'b0;

        // Back-to-back A5, 3C, then the first fill word when data runs out.
        send(1'b0, 8'hA5, t);
        push_word(1'b0, t + 2, 8'hA5, 8, 1'b0);
        send(1'b0, 8'h3C, t2);
        check("b2b_xfer_edge", t2, t + 2);
        push_word(1'b0, t + 10, 8'h3C, 8, 1'b0);
        push_prbs(t + 18, 8, 1'b1);
        wait_cyc(t + 27);

        // Gap: FF, two fill words, then 96 aligned to the next word boundary.
        reset_a(2'd0);
        send(1'b0, 8'hFF, t);
        push_word(1'b0, t + 2, 8'hFF, 8, 1'b0);
        push_prbs(t + 10, 16, 1'b1);
        repeat (20) @(negedge clk);
        send(1'b0, 8'h96, t2);
        check("gap_xfer_edge", t2, t + 21);
        push_word(1'b0, t + 26, 8'h96, 8, 1'b0);
        wait_cyc(t + 35);

        // PRBS7 mode, 254 bits from the seed.
        reset_a(2'd1);
        k = cyc;
        push_prbs(k + 2, 254, 1'b0);
        wait_cyc(k + 1);
        run  = 0;
        maxr = 0;
        repeat (254) begin
            @(negedge clk);
            run = (out_a === 1'b0) ? run + 1 : 0;
            if (run > maxr) maxr = run;
        end
        check("prbs_max_zero_run", maxr, 32'd6);

        // CLK selected mid-word with a word held; back to DATA releases it.
        reset_a(2'd0);
        send(1'b0, 8'hC3, t);
        push_word(1'b0, t + 2, 8'hC3, 8, 1'b0);
        send(1'b0, 8'h5A, t2);
        wait_cyc(t + 4);
        mode_a = 2'd2;
        push_word(1'b0, t + 10, 8'h55, 8, 1'b0);
        push_word(1'b0, t + 18, 8'h55, 8, 1'b0);
        wait_cyc(t + 12);
        check("clk_hold_ready1", {31'd0, ready_a}, 32'd0);
        wait_cyc(t + 20);
        check("clk_hold_ready2", {31'd0, ready_a}, 32'd0);
        wait_cyc(t + 22);
        mode_a = 2'd0;
        push_word(1'b0, t + 26, 8'h5A, 8, 1'b0);
        wait_cyc(t + 28);
        check("clk_release_ready", {31'd0, ready_a}, 32'd1);
        wait_cyc(t + 35);

        // Reset at cnt=3 with a word held.
        reset_a(2'd0);
        send(1'b0, 8'hE7, t);
        push_word(1'b0, t + 2, 8'hE7, 3, 1'b0);
        send(1'b0, 8'h81, t2);
        wait_cyc(t + 4);
        #2 rst_a = 1'b1;
        #1;
        check("midrst_out",      {31'd0, out_a},      32'd0);
        check("midrst_frame",    {31'd0, frame_a},    32'd0);
        check("midrst_underrun", {31'd0, underrun_a}, 32'd0);
        check("midrst_ready",    {31'd0, ready_a},    32'd1);
        @(negedge clk);
        rst_a  = 1'b0;
        m_lfsr = 7'h7F;
        send(1'b0, 8'h42, t);
        push_word(1'b0, t + 2, 8'h42, 8, 1'b0);
        wait_cyc(t + 11);

        // WIDTH=4, MSB first: 1000 -> 1,0,0,0 then 0110 -> 0,1,1,0.
        @(negedge clk);
        rst_b = 1'b0;
        send(1'b1, 8'h08, t);
        push_word(1'b1, t + 2, 8'h01, 4, 1'b0);
        send(1'b1, 8'h06, t2);
        push_word(1'b1, t + 6, 8'h06, 4, 1'b0);
        wait_cyc(t + 12);

        check("scoreboard_a_drained", qa.size(), 32'd0);
        check("scoreboard_b_drained", qb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_serializer.md
# tx_serializer

Word-to-bit serializer that sits directly upstream of the TX driver. It accepts parallel data words through a valid/ready handshake and emits one bit per `clk` on `out`, which feeds the driver's data input. It also provides built-in test patterns (PRBS7, clock pattern) and fills gaps with PRBS7 words when upstream data is late, so the line always carries transitions.

## Interface
- `WIDTH`, 8: parallel word width in bits; legal range 2..64.
- `LSB_FIRST`, 1: 1 = `din[0]` is serialized first; 0 = `din[WIDTH-1]` is serialized first.
- `PRBS_SEED`, 7'h7F: PRBS7 LFSR reset value; a zero value is replaced by 7'h01.
- `clk`  in  1  bit clock, shared with the TX driver; every bit lasts one period.
- `rst`  in  1  reset, asynchronous and active-high.
- `din`  in  WIDTH  parallel data word.
- `din_valid`  in  1  `din` is valid.
- `din_ready`  out  1  block can accept `din` this cycle.
- `mode`  in  2  pattern select: 0 = DATA, 1 = PRBS7, 2 = CLK (1010…), 3 = ZERO.
- `out`  out  1  serial bit, registered; goes to the driver `in`.
- `frame`  out  1  high during the first bit of each word.
- `underrun`  out  1  one-cycle pulse when a PRBS7 fill word replaces missing data.

## Operation
- Datapath:
  - Holding register `hold` with flag `hold_v`.
  - WIDTH-bit shift register `sreg`.
  - Bit counter `cnt` (0..WIDTH-1).
  - 7-bit LFSR, polynomial x^7+x^6+1.
- FSM:
  - IDLE: after reset; `out`=0, `frame`=0, LFSR frozen.
  - IDLE→RUN: at the first edge where `hold_v`=1 or `mode`≠DATA.
  - RUN→IDLE: only through reset.
- Handshake:
  - A transfer occurs on a rising edge with `din_valid & din_ready`.
  - `din_ready` = `~hold_v | last`, where `last` = RUN & `cnt`==WIDTH-1. It is combinational from state only, never from `din_valid`.
  - If `din_valid` is held without ready, `din` must stay stable; the block does not check this.
- Word load happens at the IDLE→RUN edge, or in RUN when `last`=1. `mode` is sampled only at this load:
  - DATA with `hold_v`: `sreg`←`hold`; `hold_v` clears unless a new transfer happens on the same edge. Simultaneous load and refill is legal and keeps a back-to-back stream gap-free.
  - DATA without `hold_v` (RUN only): `sreg`←next WIDTH PRBS7 bits; `underrun` pulses for the first bit of that word.
  - PRBS7: `sreg` takes WIDTH PRBS7 bits; the LFSR advances one step per emitted bit.
  - CLK: `sreg`=…0101 in serialization order, so the first bit is 1.
  - ZERO: `sreg`=0.
  - In CLK and ZERO modes, accepted DATA words still occupy `hold` and wait there.
- Shift: each RUN cycle, `out` takes the next bit in `LSB_FIRST` order and `cnt` increments, wrapping WIDTH-1→0. `frame`=1 when the emitted bit is bit index 0 of the word.
- The LFSR output bit is LFSR[6]. The fill and PRBS streams are one continuous sequence, with no reseeding between words.

## Timing
- Reset values: `out`=0, `frame`=0, `underrun`=0, `din_ready`=1, `hold_v`=0, `cnt`=0, LFSR=`PRBS_SEED`, state IDLE.
- Latency from IDLE: word accepted at edge t → `hold` at t → first bit on `out` after edge t+2.
- Steady state: one word per WIDTH cycles, zero bubbles if `din_valid` is asserted whenever `din_ready`=1.
- `mode` change mid-word: no effect until the next word boundary.
- Reset asserted mid-word: all state returns to reset values immediately (asynchronous). The partial word and `hold` are discarded, with no `underrun` pulse. After release, behaviour restarts as from IDLE.

## Structure
- Package `tx_ser_pkg`: `mode_e` enum (DATA, PRBS7, CLK, ZERO), `state_e` enum (IDLE, RUN), PRBS7 tap constants, and function `prbs7_next`.
- One sub-module, `prbs7_gen`, containing the LFSR with a `step` enable and a seed parameter. Everything else is flat in `tx_serializer`.

## Test plan
- Back-to-back, WIDTH=8, LSB_FIRST=1: words 0xA5, 0x3C → `out` = 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; `frame` high on bits 0 and 8; `underrun` never pulses.
- Gap: word 0xFF, then `din_valid` low for 20 cycles → after 8 ones, a PRBS7 fill word from seed 7'h7F; `underrun` pulses on the fill word's first bit; the next data word starts aligned with `frame`.
- PRBS7 mode for 254 bits → sequence period 127, matching the `prbs7_next` reference model, with no all-zero run longer than 6 bits.
- CLK mode selected while a DATA word is mid-shift → the current word completes, then `out` toggles 1,0,1,0…; a held DATA word remains with `din_ready`=0.
- Reset mid-word (`cnt`=3, `hold_v`=1) → `out`, `frame`, `underrun` all 0 immediately; `din_ready`=1; the next accepted word appears 2 cycles after its transfer.
- LSB_FIRST=0, WIDTH=4: word 4'b1000 → `out` = 1,0,0,0.
